// File: rtl/uart_word_tx.sv
// uart_word_tx
//
// Serializes 32-bit words from an AXI-stream-style slave port into bytes for
// the UART transmitter, most significant byte first. Words are queued in a
// small FIFO. Each byte is issued as a one-cycle write strobe, and then the
// block waits for the UART to drop busy before it sends the next byte.
//
// Build option:
//   UART_WORD_TX_CHECKSUM_EN - when defined, a fifth byte follows every word.
//                              It is the XOR of the four data bytes.
//
// Handshake: a word is transferred on a rising clk_pix edge where
// s_axis_tvalid_i && s_axis_tready_o. tready is a function of the registered
// FIFO level and reset only; it never depends on tvalid.
//
// Ports:
//   clk_pix          pixel clock; all logic is on its rising edge
//   reset            synchronous, active-high reset
//   s_axis_tvalid_i  producer has a word
//   s_axis_tready_o  FIFO has room
//   s_axis_tdata_i   word to send
//   uart_wr_o        one-cycle write strobe to uart.wr_i
//   uart_tx_data_o   byte to uart.tx_data_i; holds between strobes
//   uart_busy_i      uart.busy_o
//   fifo_level_o     words held in the FIFO
//   idle_o           FIFO empty, FSM idle and UART not busy
//   fsm_state_o      current FSM state, for observation
module uart_word_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_pix,
    input  logic                          reset,
    input  logic                          s_axis_tvalid_i,
    output logic                          s_axis_tready_o,
    input  logic [31:0]                   s_axis_tdata_i,
    output logic                          uart_wr_o,
    output logic [7:0]                    uart_tx_data_o,
    input  logic                          uart_busy_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          idle_o,
    output logic [1:0]                    fsm_state_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

`ifdef UART_WORD_TX_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_GUARD = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // ---------------- FIFO ----------------
    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             push;
    logic             pop;

    // The registered level drives tready. As a result, a pop from a full
    // FIFO frees the slot only in the following cycle.
    assign s_axis_tready_o = !reset && (level < LVL_FULL);
    assign push            = s_axis_tvalid_i && s_axis_tready_o;
    assign fifo_level_o    = level;

    always_ff @(posedge clk_pix) begin
        if (push) begin
            mem[wr_ptr] <= s_axis_tdata_i;
        end
    end

    // The depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // ---------------- Serializer FSM ----------------
    state_t      state, state_nxt;
    logic [31:0] shift, shift_nxt;
    logic [2:0]  byte_cnt, cnt_nxt;
    logic        wr_nxt;
    logic [7:0]  data_nxt;
`ifdef UART_WORD_TX_CHECKSUM_EN
    logic [7:0]  csum, csum_nxt;
`endif

    always_comb begin
        state_nxt = state;
        shift_nxt = shift;
        cnt_nxt   = byte_cnt;
        wr_nxt    = 1'b0;
        data_nxt  = uart_tx_data_o;
        pop       = 1'b0;
`ifdef UART_WORD_TX_CHECKSUM_EN
        csum_nxt  = csum;
`endif
        case (state)
            ST_IDLE: begin
                if (level != '0) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    cnt_nxt   = 3'd0;
`ifdef UART_WORD_TX_CHECKSUM_EN
                    csum_nxt  = 8'h00;
`endif
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!uart_busy_i) begin
                    wr_nxt    = 1'b1;
                    data_nxt  = shift[31:24];
`ifdef UART_WORD_TX_CHECKSUM_EN
                    csum_nxt  = csum ^ shift[31:24];
`endif
                    state_nxt = ST_GUARD;
                end
            end
            // The UART raises busy one cycle after the strobe, so busy is
            // not examined in this cycle.
            ST_GUARD: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!uart_busy_i) begin
                    if (byte_cnt == LAST_IDX) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt   = byte_cnt + 3'd1;
                        state_nxt = ST_SEND;
`ifdef UART_WORD_TX_CHECKSUM_EN
                        // After the last data byte, put the checksum in the
                        // top byte so that SEND handles it like any other byte.
                        if (byte_cnt == 3'd3) begin
                            shift_nxt = {csum, 24'h000000};
                        end else begin
                            shift_nxt = {shift[23:0], 8'h00};
                        end
`else
                        shift_nxt = {shift[23:0], 8'h00};
`endif
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (reset) begin
            shift          <= '0;
            byte_cnt       <= 3'd0;
            uart_wr_o      <= 1'b0;
            uart_tx_data_o <= 8'h00;
`ifdef UART_WORD_TX_CHECKSUM_EN
            csum           <= 8'h00;
`endif
        end else begin
            shift          <= shift_nxt;
            byte_cnt       <= cnt_nxt;
            uart_wr_o      <= wr_nxt;
            uart_tx_data_o <= data_nxt;
`ifdef UART_WORD_TX_CHECKSUM_EN
            csum           <= csum_nxt;
`endif
        end
    end

    assign idle_o      = (level == '0) && (state == ST_IDLE) && !uart_busy_i;
    assign fsm_state_o = state;

endmodule

// File: tb/tb_uart_word_tx.sv
// Testbench for uart_word_tx: directed words, a UART busy model, and a
// scoreboard of expected bytes that a negedge monitor checks.
module tb_uart_word_tx;

    localparam int FIFO_DEPTH = 4;
    localparam int BUSY_CYC   = 10;
    localparam int ST_IDLE    = 0;
    localparam int ST_SEND    = 1;
`ifdef UART_WORD_TX_CHECKSUM_EN
    localparam int BPW = 5;
`else
    localparam int BPW = 4;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk_pix = 1'b0;
    logic        reset = 1'b1;
    logic        s_axis_tvalid_i = 1'b0;
    logic        s_axis_tready_o;
    logic [31:0] s_axis_tdata_i = 32'h0;
    logic        uart_wr_o;
    logic [7:0]  uart_tx_data_o;
    logic        uart_busy_i;
    logic [$clog2(FIFO_DEPTH):0] fifo_level_o;
    logic        idle_o;
    logic [1:0]  fsm_state_o;

    logic        force_busy = 1'b0;
    int          busy_cnt = 0;
    int          cyc = 0;

    always #5 clk_pix = ~clk_pix;
    always @(posedge clk_pix) cyc <= cyc + 1;

    uart_word_tx #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_pix         (clk_pix),
        .reset           (reset),
        .s_axis_tvalid_i (s_axis_tvalid_i),
        .s_axis_tready_o (s_axis_tready_o),
        .s_axis_tdata_i  (s_axis_tdata_i),
        .uart_wr_o       (uart_wr_o),
        .uart_tx_data_o  (uart_tx_data_o),
        .uart_busy_i     (uart_busy_i),
        .fifo_level_o    (fifo_level_o),
        .idle_o          (idle_o),
        .fsm_state_o     (fsm_state_o)
    );

    // UART model: busy rises the cycle after a strobe and lasts BUSY_CYC cycles.
    assign uart_busy_i = force_busy || (busy_cnt != 0);
    always @(posedge clk_pix) begin
        if (uart_wr_o)         busy_cnt <= BUSY_CYC;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int         strobe_cyc[$];
    int         n_strobe = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    logic       prev_wr = 1'b0;
    logic [7:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic [31:0] w);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(w[31 - 8*i -: 8]);
            x = x ^ w[31 - 8*i -: 8];
        end
`ifdef UART_WORD_TX_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // Monitor: every strobe pops one expected byte.
    always @(negedge clk_pix) begin
        if (uart_wr_o) begin
            strobe_cyc.push_back(cyc);
            n_strobe++;
            check("wr_not_consecutive", {31'd0, prev_wr}, 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_strobe: got byte 0x%0h, required no strobe (cycle %0d)",
                         uart_tx_data_o, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                check("tx_byte", {24'd0, uart_tx_data_o}, {24'd0, mon_exp});
            end
        end
        prev_wr = uart_wr_o;
    end

    // ---------------- driver tasks ----------------
    // The current tdata is held with tvalid high until accepted. Returns just
    // after the accepting edge, with tvalid still high.
    task automatic accept_current(input int budget, output int acc_cyc);
        int k;
        k = 0;
        acc_cyc = -1;
        while (!s_axis_tready_o && k < budget) begin
            @(negedge clk_pix);
            k++;
        end
        if (!s_axis_tready_o) begin
            n_cmp++;
            n_fail++;
            $display("FAIL push_timeout: got tready=0, required 1 within %0d cycles", budget);
            s_axis_tvalid_i = 1'b0;
        end else begin
            acc_cyc = cyc;
            push_exp(s_axis_tdata_i);
            @(posedge clk_pix);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input int budget, output int acc_cyc);
        @(negedge clk_pix);
        s_axis_tvalid_i = 1'b1;
        s_axis_tdata_i  = w;
        accept_current(budget, acc_cyc);
    endtask

    task automatic drop_valid();
        @(negedge clk_pix);
        s_axis_tvalid_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int idle_cyc);
        int k;
        k = 0;
        idle_cyc = -1;
        @(negedge clk_pix);
        while (!idle_o && k < budget) begin
            @(negedge clk_pix);
            k++;
        end
        if (!idle_o) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: got idle_o=0, required 1 within %0d cycles", budget);
        end else begin
            idle_cyc = cyc;
            check("idle_only_after_last_byte", exp_q.size(), 0);
        end
    endtask

    function automatic int strobe_at(input int idx);
        if (idx < strobe_cyc.size()) return strobe_cyc[idx];
        return -1000;
    endfunction

    logic [31:0] words [16] = '{
        32'h0123_4567, 32'h89AB_CDEF, 32'hFFFF_0000, 32'h0000_FFFF,
        32'h5A5A_A5A5, 32'h8000_0001, 32'h7F7F_7F7F, 32'hCAFE_F00D,
        32'h1234_ABCD, 32'h0F0F_F0F0, 32'h00FF_00FF, 32'hBEEF_DEAD,
        32'h1357_9BDF, 32'h2468_ACE0, 32'hFEDC_BA98, 32'h0000_0000
    };

    // ---------------- test sequence ----------------
    initial begin
        int acc;
        int base;
        int rel;
        int idle_c;
        int k;

        // Reset state
        repeat (3) @(negedge clk_pix);
        check("rst_tready", {31'd0, s_axis_tready_o}, 32'd0);
        check("rst_wr", {31'd0, uart_wr_o}, 32'd0);
        check("rst_data", {24'd0, uart_tx_data_o}, 32'd0);
        check("rst_level", {29'd0, fifo_level_o}, 32'd0);
        check("rst_idle", {31'd0, idle_o}, 32'd1);
        check("rst_state", {30'd0, fsm_state_o}, ST_IDLE);
        reset = 1'b0;
        #1;
        check("tready_after_reset", {31'd0, s_axis_tready_o}, 32'd1);

        // T1: single word, latency and byte spacing
        base = n_strobe;
        push_word(32'hDEADBEEF, 10, acc);
        drop_valid();
        wait_idle(500, idle_c);
        check("t1_strobe_count", n_strobe - base, BPW);
        check("t1_first_latency", strobe_at(base) - acc, 3);
        check("t1_byte_gap", strobe_at(base + 1) - strobe_at(base), BUSY_CYC + 3);
        check("t1_byte_gap3", strobe_at(base + 3) - strobe_at(base + 2), BUSY_CYC + 3);

        // T2: fill the FIFO while busy is held high, then a sixth word waits
        force_busy = 1'b1;
        base = n_strobe;
        for (int i = 0; i < 5; i++) push_word(words[i], 5, acc);
        @(negedge clk_pix);
        s_axis_tdata_i = words[5];
        check("t2_level_full", {29'd0, fifo_level_o}, 32'd4);
        check("t2_tready_full", {31'd0, s_axis_tready_o}, 32'd0);
        repeat (20) @(negedge clk_pix);
        check("t2_tready_held", {31'd0, s_axis_tready_o}, 32'd0);
        check("t2_level_held", {29'd0, fifo_level_o}, 32'd4);
        force_busy = 1'b0;
        accept_current(1000, acc);
        drop_valid();
        wait_idle(3000, idle_c);
        check("t2_strobe_count", n_strobe - base, 6 * BPW);
        check("t2_word_gap", strobe_at(base + BPW) - strobe_at(base + BPW - 1), BUSY_CYC + 4);

        // T3: push and pop in the same cycle at level 2
        force_busy = 1'b1;
        push_word(32'hA0A1A2A3, 5, acc);
        push_word(32'hB0B1B2B3, 5, acc);
        push_word(32'hC0C1C2C3, 5, acc);
        drop_valid();
        check("t3_level2", {29'd0, fifo_level_o}, 32'd2);
        force_busy = 1'b0;
        k = 0;
        while (fsm_state_o != 2'(ST_IDLE) && k < 500) begin
            @(negedge clk_pix);
            k++;
        end
        check("t3_reached_idle", {30'd0, fsm_state_o}, ST_IDLE);
        s_axis_tvalid_i = 1'b1;
        s_axis_tdata_i  = 32'hD0D1D2D3;
        check("t3_tready", {31'd0, s_axis_tready_o}, 32'd1);
        push_exp(s_axis_tdata_i);
        @(posedge clk_pix);
        drop_valid();
        check("t3_level_unchanged", {29'd0, fifo_level_o}, 32'd2);
        wait_idle(3000, idle_c);

        // T4: busy stuck high in SEND for 100 cycles
        force_busy = 1'b1;
        base = n_strobe;
        push_word(32'h0BAD_F00D, 5, acc);
        drop_valid();
        repeat (100) @(negedge clk_pix);
        check("t4_no_strobe", n_strobe - base, 0);
        check("t4_in_send", {30'd0, fsm_state_o}, ST_SEND);
        force_busy = 1'b0;
        rel = cyc;
        wait_idle(1000, idle_c);
        check("t4_release_latency", strobe_at(base) - rel, 1);

        // T5: reset in WAIT after byte 1 with two words queued
        force_busy = 1'b1;
        push_word(32'h11223344, 5, acc);
        push_word(32'h55667788, 5, acc);
        push_word(32'h99AABBCC, 5, acc);
        drop_valid();
        base = n_strobe;
        force_busy = 1'b0;
        k = 0;
        while ((n_strobe - base) < 2 && k < 500) begin
            @(negedge clk_pix);
            k++;
        end
        repeat (3) @(negedge clk_pix);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk_pix);
        check("t5_wr", {31'd0, uart_wr_o}, 32'd0);
        check("t5_data", {24'd0, uart_tx_data_o}, 32'd0);
        check("t5_level", {29'd0, fifo_level_o}, 32'd0);
        check("t5_tready", {31'd0, s_axis_tready_o}, 32'd0);
        check("t5_state", {30'd0, fsm_state_o}, ST_IDLE);
        reset = 1'b0;
        repeat (40) @(negedge clk_pix);
        check("t5_no_more_strobes", n_strobe - base, 2);
        check("t5_idle", {31'd0, idle_o}, 32'd1);
        push_word(32'hA5A5A5A5, 5, acc);
        drop_valid();
        wait_idle(500, idle_c);
        check("t5_new_word", n_strobe - base, 2 + BPW);

        // T6: 16-word continuous stream
        base = n_strobe;
        for (int i = 0; i < 16; i++) push_word(words[i], 1000, acc);
        drop_valid();
        wait_idle(5000, idle_c);
        check("t6_strobe_count", n_strobe - base, 16 * BPW);
        check("t6_idle_after_last", idle_c - strobe_at(n_strobe - 1), BUSY_CYC + 2);

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, required finish within 100000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
